// File: rtl/csr_access_ctrl_pkg.sv
// csr_access_ctrl_pkg: shared widths, CSR funct3 codes, FSM state encoding,
// read-only address field position and the latched instruction payload.
package csr_access_ctrl_pkg;

   localparam int unsigned MXLEN = 32;   // CSR data width
   localparam int unsigned AW    = 12;   // CSR address width
   localparam int unsigned RW    = 5;    // GPR index / uimm width
   localparam int unsigned F3W   = 3;    // funct3 width

   localparam logic [F3W-1:0] F3_CSRRW  = 3'b001;
   localparam logic [F3W-1:0] F3_CSRRS  = 3'b010;
   localparam logic [F3W-1:0] F3_CSRRC  = 3'b011;
   localparam logic [F3W-1:0] F3_CSRRWI = 3'b101;
   localparam logic [F3W-1:0] F3_CSRRSI = 3'b110;
   localparam logic [F3W-1:0] F3_CSRRCI = 3'b111;

   // Read-only CSRs live where addr[11:10] == 2'b11
   localparam int unsigned RO_MSB = 11;
   localparam int unsigned RO_LSB = 10;
   localparam logic [1:0]  RO_VAL = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TWR  = 2'd1,
      RD   = 2'd2,
      RMW  = 2'd3
   } state_t;

   typedef struct packed {
      logic [AW-1:0]    addr;
      logic [F3W-1:0]   funct3;
      logic [MXLEN-1:0] rs1_data;
      logic [RW-1:0]    uimm;
      logic [RW-1:0]    rd;
   } ins_req_t;

   // funct3 low bits 00 (000 and 100) are not CSR ops
   function automatic logic f3_legal(input logic [F3W-1:0] f3);
      return f3[1:0] != 2'b00;
   endfunction

   // CSRRW / CSRRWI
   function automatic logic f3_is_rw(input logic [F3W-1:0] f3);
      return f3[1:0] == 2'b01;
   endfunction

endpackage

// File: rtl/csr_access_ctrl_if.sv
// csr_access_ctrl_if: instruction, trap, write-back and RAM signals of
// csr_access_ctrl. slave = the controller, master = its environment.
interface csr_access_ctrl_if;
   import csr_access_ctrl_pkg::*;

   logic             i_ins_valid;
   logic             o_ins_ready;
   logic [AW-1:0]    i_ins_addr;
   logic [F3W-1:0]   i_ins_funct3;
   logic [MXLEN-1:0] i_ins_rs1_data;
   logic [RW-1:0]    i_ins_rs1_uimm;
   logic [RW-1:0]    i_ins_rd_addr;
   logic             o_rd_valid;
   logic [MXLEN-1:0] o_rd_data;
   logic [RW-1:0]    o_rd_addr;
   logic             o_ins_done;
   logic             o_ins_illegal;
   logic             i_trp_valid;
   logic             o_trp_ready;
   logic [AW-1:0]    i_trp_addr;
   logic [MXLEN-1:0] i_trp_wdata;
   logic             o_mem_en;
   logic             o_mem_we;
   logic [AW-1:0]    o_mem_addr;
   logic [MXLEN-1:0] o_mem_wdata;
   logic [MXLEN-1:0] i_mem_rdata;

   modport slave (
      input  i_ins_valid, i_ins_addr, i_ins_funct3, i_ins_rs1_data,
             i_ins_rs1_uimm, i_ins_rd_addr, i_trp_valid, i_trp_addr,
             i_trp_wdata, i_mem_rdata,
      output o_ins_ready, o_rd_valid, o_rd_data, o_rd_addr, o_ins_done,
             o_ins_illegal, o_trp_ready, o_mem_en, o_mem_we, o_mem_addr,
             o_mem_wdata
   );

   modport master (
      output i_ins_valid, i_ins_addr, i_ins_funct3, i_ins_rs1_data,
             i_ins_rs1_uimm, i_ins_rd_addr, i_trp_valid, i_trp_addr,
             i_trp_wdata, i_mem_rdata,
      input  o_ins_ready, o_rd_valid, o_rd_data, o_rd_addr, o_ins_done,
             o_ins_illegal, o_trp_ready, o_mem_en, o_mem_we, o_mem_addr,
             o_mem_wdata
   );

endinterface

// File: rtl/csr_rmw_alu.sv
// csr_rmw_alu: combinational new-value computation for CSR read-modify-write.
// Ports: funct3 (op), old_val, rs1_data, uimm (zero-extended for the
// immediate forms) -> new_val.
module csr_rmw_alu
   import csr_access_ctrl_pkg::*;
(
   input  logic [F3W-1:0]   funct3,
   input  logic [MXLEN-1:0] old_val,
   input  logic [MXLEN-1:0] rs1_data,
   input  logic [RW-1:0]    uimm,
   output logic [MXLEN-1:0] new_val
);

   logic [MXLEN-1:0] operand;

   always_comb begin
      operand = funct3[2] ? MXLEN'(uimm) : rs1_data;
      new_val = old_val;
      case (funct3[1:0])
         2'b01:   new_val = operand;
         2'b10:   new_val = old_val | operand;
         2'b11:   new_val = old_val & ~operand;
         default: new_val = old_val;
      endcase
   end

endmodule

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: sequences CSR instruction read-modify-writes and trap
// writes onto a single-port, one-cycle-latency CSR RAM.
// Ports: i_clk, i_rst (synchronous, active-high), bus (csr_access_ctrl_if
// slave modport: instruction request, trap request, rd write-back, RAM port).
// Optional: define CSR_RO_CHECK_EN to flag write-enabled instructions to
// read-only CSRs (addr[11:10] == 2'b11) as illegal.
module csr_access_ctrl
   import csr_access_ctrl_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   csr_access_ctrl_if.slave  bus
);

   state_t           state;
   ins_req_t         req_q;
   logic             wen_q, ren_q, ill_q;
   logic [MXLEN-1:0] trp_wdata_q;

   logic             ins_ready_q, trp_ready_q;
   logic             mem_en_q, mem_we_q;
   logic [AW-1:0]    mem_addr_q;
   logic             done_q, ill_out_q, rd_valid_q;
   logic [RW-1:0]    rd_addr_q;

   logic             dec_legal, dec_wen, dec_ren, dec_ro;
   logic             c_wen, c_ill;
   logic [AW-1:0]    c_addr;
   logic [RW-1:0]    c_rd;
   logic [MXLEN-1:0] old_val, new_val;

   // Decode of the request currently presented on the instruction port
   always_comb begin
      dec_legal = f3_legal(bus.i_ins_funct3);
      dec_wen   = f3_is_rw(bus.i_ins_funct3) || (bus.i_ins_rs1_uimm != '0);
      dec_ren   = !f3_is_rw(bus.i_ins_funct3) || (bus.i_ins_rd_addr != '0);
`ifdef CSR_RO_CHECK_EN
      dec_ro    = dec_wen && (bus.i_ins_addr[RO_MSB:RO_LSB] == RO_VAL);
`else
      dec_ro    = 1'b0;
`endif
   end

   // Controls for the RMW cycle: fresh decode when entered from IDLE,
   // latched values when entered from RD
   always_comb begin
      if (state == IDLE) begin
         c_wen  = dec_legal && !dec_ro && dec_wen;
         c_ill  = !dec_legal || dec_ro;
         c_addr = bus.i_ins_addr;
         c_rd   = bus.i_ins_rd_addr;
      end else begin
         c_wen  = wen_q;
         c_ill  = ill_q;
         c_addr = req_q.addr;
         c_rd   = req_q.rd;
      end
   end

   // Old value is zero when no read was issued
   assign old_val = ren_q ? bus.i_mem_rdata : '0;

   csr_rmw_alu u_alu (
      .funct3   (req_q.funct3),
      .old_val  (old_val),
      .rs1_data (req_q.rs1_data),
      .uimm     (req_q.uimm),
      .new_val  (new_val)
   );

   // FSM, request latch and registered control outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         req_q       <= '0;
         wen_q       <= 1'b0;
         ren_q       <= 1'b0;
         ill_q       <= 1'b0;
         trp_wdata_q <= '0;
         ins_ready_q <= 1'b0;
         trp_ready_q <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         done_q      <= 1'b0;
         ill_out_q   <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_addr_q   <= '0;
      end else begin
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         done_q     <= 1'b0;
         ill_out_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_addr_q  <= '0;
         case (state)
            IDLE: begin
               ins_ready_q <= 1'b1;
               trp_ready_q <= 1'b1;
               if (trp_ready_q && bus.i_trp_valid) begin
                  // Trap has fixed priority over a pending instruction
                  state       <= TWR;
                  ins_ready_q <= 1'b0;
                  trp_ready_q <= 1'b0;
                  trp_wdata_q <= bus.i_trp_wdata;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= bus.i_trp_addr;
               end else if (ins_ready_q && bus.i_ins_valid) begin
                  ins_ready_q <= 1'b0;
                  trp_ready_q <= 1'b0;
                  req_q       <= '{addr:     bus.i_ins_addr,
                                   funct3:   bus.i_ins_funct3,
                                   rs1_data: bus.i_ins_rs1_data,
                                   uimm:     bus.i_ins_rs1_uimm,
                                   rd:       bus.i_ins_rd_addr};
                  wen_q       <= c_wen;
                  ill_q       <= c_ill;
                  ren_q       <= dec_legal && dec_ren;
                  if (dec_legal && dec_ren) begin
                     state      <= RD;
                     mem_en_q   <= 1'b1;
                     mem_addr_q <= bus.i_ins_addr;
                  end else begin
                     state      <= RMW;
                     mem_en_q   <= c_wen;
                     mem_we_q   <= c_wen;
                     mem_addr_q <= c_wen ? c_addr : '0;
                     done_q     <= 1'b1;
                     ill_out_q  <= c_ill;
                     rd_valid_q <= !c_ill && (c_rd != '0);
                     rd_addr_q  <= (!c_ill && (c_rd != '0)) ? c_rd : '0;
                  end
               end
            end
            RD: begin
               state      <= RMW;
               mem_en_q   <= c_wen;
               mem_we_q   <= c_wen;
               mem_addr_q <= c_wen ? c_addr : '0;
               done_q     <= 1'b1;
               ill_out_q  <= c_ill;
               rd_valid_q <= !c_ill && (c_rd != '0);
               rd_addr_q  <= (!c_ill && (c_rd != '0)) ? c_rd : '0;
            end
            TWR, RMW: begin
               state       <= IDLE;
               ins_ready_q <= 1'b1;
               trp_ready_q <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_ins_ready   = ins_ready_q;
   assign bus.o_trp_ready   = trp_ready_q;
   assign bus.o_mem_en      = mem_en_q;
   assign bus.o_mem_we      = mem_we_q;
   assign bus.o_mem_addr    = mem_addr_q;
   assign bus.o_ins_done    = done_q;
   assign bus.o_ins_illegal = ill_out_q;
   assign bus.o_rd_valid    = rd_valid_q;
   assign bus.o_rd_addr     = rd_addr_q;
   // Data outputs follow the RAM read data during RMW
   assign bus.o_rd_data     = rd_valid_q ? old_val : '0;
   assign bus.o_mem_wdata   = !mem_we_q      ? '0 :
                              (state == TWR) ? trp_wdata_q : new_val;

endmodule
